// File: rtl/avalon_octa_sram_slave.sv
// Avalon-MM slave that splits 64-bit octa accesses into two 32-bit beats
// on a synchronous single-port tetra RAM with RAM_LAT cycles of read latency.
module avalon_octa_sram_slave #(
  parameter int unsigned ADDR_W  = 22,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [27:0]       s_address,
  input  logic [7:0]        s_byteenable,
  input  logic              s_read,
  input  logic              s_write,
  input  logic [63:0]       s_writedata,
  output logic [63:0]       s_readdata,
  output logic              s_waitrequest,
  output logic              s_readdatavalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_re,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int unsigned OW   = ADDR_W - 1;
  localparam int unsigned LAST = RAM_LAT - 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_LO   = 3'd1,
    WR_HI   = 3'd2,
    RD_LO   = 3'd3,
    RD_HI   = 3'd4,
    RD_WAIT = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [OW-1:0]       oaddr_q, oaddr_d;
  logic [7:0]          be_q, be_d;
  logic [63:0]         wdata_q, wdata_d;
  logic                ram_re_q, ram_re_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [3:0]          ram_be_q, ram_be_d;
  logic [31:0]         ram_wdata_q, ram_wdata_d;
  logic [RAM_LAT-1:0]  pv_q, pv_d;
  logic [RAM_LAT-1:0]  pt_q, pt_d;
  logic [31:0]         lo_q, lo_d;
  logic [63:0]         rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                unused_addr;

  assign s_waitrequest   = (state_q != IDLE);
  assign s_readdata      = rdata_q;
  assign s_readdatavalid = rvalid_q;
  assign ram_addr        = ram_addr_q;
  assign ram_re          = ram_re_q;
  assign ram_we          = ram_we_q;
  assign ram_be          = ram_be_q;
  assign ram_wdata       = ram_wdata_q;
  assign unused_addr     = ^{s_address[27:ADDR_W+2], s_address[2:0]};

  // Command acceptance, beat sequencing and registered RAM strobes
  always_comb begin
    state_d     = state_q;
    oaddr_d     = oaddr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    ram_re_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_be_d    = ram_be_q;
    ram_wdata_d = ram_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (s_read || s_write) begin
          oaddr_d = s_address[ADDR_W+1:3];
          be_d    = s_byteenable;
          wdata_d = s_writedata;
        end
        if (s_read) begin
          state_d    = RD_LO;
          ram_re_d   = 1'b1;
          ram_addr_d = {s_address[ADDR_W+1:3], 1'b0};
        end else if (s_write) begin
          if (s_byteenable[3:0] != 4'h0) begin
            state_d     = WR_LO;
            ram_we_d    = 1'b1;
            ram_addr_d  = {s_address[ADDR_W+1:3], 1'b0};
            ram_be_d    = s_byteenable[3:0];
            ram_wdata_d = s_writedata[31:0];
          end else if (s_byteenable[7:4] != 4'h0) begin
            state_d     = WR_HI;
            ram_we_d    = 1'b1;
            ram_addr_d  = {s_address[ADDR_W+1:3], 1'b1};
            ram_be_d    = s_byteenable[7:4];
            ram_wdata_d = s_writedata[63:32];
          end
        end
      end
      WR_LO: begin
        if (be_q[7:4] != 4'h0) begin
          state_d     = WR_HI;
          ram_we_d    = 1'b1;
          ram_addr_d  = {oaddr_q, 1'b1};
          ram_be_d    = be_q[7:4];
          ram_wdata_d = wdata_q[63:32];
        end else begin
          state_d = IDLE;
        end
      end
      WR_HI: state_d = IDLE;
      RD_LO: begin
        state_d    = RD_HI;
        ram_re_d   = 1'b1;
        ram_addr_d = {oaddr_q, 1'b1};
      end
      RD_HI: state_d = RD_WAIT;
      RD_WAIT: begin
        if (pv_q[LAST] && pt_q[LAST]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read-return pipe: tracks each RAM read and whether it is the hi beat
  always_comb begin
    pv_d    = '0;
    pt_d    = '0;
    pv_d[0] = ram_re_q;
    pt_d[0] = (state_q == RD_HI);
    for (int unsigned i = 1; i < RAM_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pt_d[i] = pt_q[i-1];
    end
  end

  // Capture returning halves and present the assembled octa
  always_comb begin
    lo_d     = lo_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (pv_q[LAST]) begin
      if (pt_q[LAST]) begin
        rdata_d  = {ram_rdata, lo_q};
        rvalid_d = 1'b1;
      end else begin
        lo_d = ram_rdata;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      oaddr_q     <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      ram_re_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_be_q    <= '0;
      ram_wdata_q <= '0;
      pv_q        <= '0;
      pt_q        <= '0;
      lo_q        <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      oaddr_q     <= oaddr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      ram_re_q    <= ram_re_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_be_q    <= ram_be_d;
      ram_wdata_q <= ram_wdata_d;
      pv_q        <= pv_d;
      pt_q        <= pt_d;
      lo_q        <= lo_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_avalon_octa_sram_slave.sv
// Self-checking bench: two slaves (RAM_LAT=1 and RAM_LAT=3) with behavioural RAMs,
// checked against an octa-level byte-addressed memory model.
module tb_avalon_octa_sram_slave;

  localparam int unsigned ADDR_W = 22;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clr;
  logic        sel_b;
  logic [27:0] s_address;
  logic [7:0]  s_byteenable;
  logic        s_read, s_write;
  logic [63:0] s_writedata;

  logic [63:0]       a_rdata, b_rdata;
  logic              a_wait, b_wait, a_rv, b_rv, a_re, b_re, a_we, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [3:0]        a_be, b_be;
  logic [31:0]       a_wdata, b_wdata, a_rrd, b_rrd;

  logic [63:0]       w_rdata;
  logic              w_wait, w_rv, w_re, w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;

  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];
  logic [31:0] pa;
  logic [31:0] pb [3];

  logic [63:0] ref_a [int];
  logic [63:0] ref_b [int];

  int checks = 0;
  int errors = 0;
  int a_rv_cnt = 0;
  int b_rv_cnt = 0;
  int a_reads = 0;

  always #5 clk = ~clk;

  avalon_octa_sram_slave #(.ADDR_W(ADDR_W), .RAM_LAT(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .s_address(s_address), .s_byteenable(s_byteenable),
    .s_read(s_read & ~sel_b), .s_write(s_write & ~sel_b), .s_writedata(s_writedata),
    .s_readdata(a_rdata), .s_waitrequest(a_wait), .s_readdatavalid(a_rv),
    .ram_addr(a_addr), .ram_re(a_re), .ram_we(a_we), .ram_be(a_be),
    .ram_wdata(a_wdata), .ram_rdata(a_rrd));

  avalon_octa_sram_slave #(.ADDR_W(ADDR_W), .RAM_LAT(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .s_address(s_address), .s_byteenable(s_byteenable),
    .s_read(s_read & sel_b), .s_write(s_write & sel_b), .s_writedata(s_writedata),
    .s_readdata(b_rdata), .s_waitrequest(b_wait), .s_readdatavalid(b_rv),
    .ram_addr(b_addr), .ram_re(b_re), .ram_we(b_we), .ram_be(b_be),
    .ram_wdata(b_wdata), .ram_rdata(b_rrd));

  assign w_rdata = sel_b ? b_rdata : a_rdata;
  assign w_wait  = sel_b ? b_wait  : a_wait;
  assign w_rv    = sel_b ? b_rv    : a_rv;
  assign w_re    = sel_b ? b_re    : a_re;
  assign w_we    = sel_b ? b_we    : a_we;
  assign w_addr  = sel_b ? b_addr  : a_addr;
  assign w_be    = sel_b ? b_be    : a_be;
  assign w_wdata = sel_b ? b_wdata : a_wdata;

  // RAM with one cycle of read latency
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem_a[i] <= '0;
    end else if (a_we) begin
      for (int i = 0; i < 4; i++)
        if (a_be[i]) mem_a[a_addr[9:0]][8*i +: 8] <= a_wdata[8*i +: 8];
    end
    pa <= mem_a[a_addr[9:0]];
  end
  assign a_rrd = pa;

  // RAM with three cycles of read latency
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem_b[i] <= '0;
    end else if (b_we) begin
      for (int i = 0; i < 4; i++)
        if (b_be[i]) mem_b[b_addr[9:0]][8*i +: 8] <= b_wdata[8*i +: 8];
    end
    pb[0] <= mem_b[b_addr[9:0]];
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign b_rrd = pb[2];

  // Count every readdatavalid pulse of each slave
  always @(negedge clk) begin
    if (a_rv) a_rv_cnt <= a_rv_cnt + 1;
    if (b_rv) b_rv_cnt <= b_rv_cnt + 1;
  end

  function automatic logic [63:0] ref_get(input int idx);
    if (sel_b) return ref_b.exists(idx) ? ref_b[idx] : 64'h0;
    return ref_a.exists(idx) ? ref_a[idx] : 64'h0;
  endfunction

  task automatic ref_put(input int idx, input logic [63:0] v);
    if (sel_b) ref_b[idx] = v;
    else ref_a[idx] = v;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [27:0] addr, input logic [7:0] be,
                          input logic [63:0] data, input bit hold_rd);
    logic [20:0] idx;
    logic [63:0] cur;
    logic        beat;
    int          nb;
    idx = addr[23:3];
    s_address = addr; s_byteenable = be; s_writedata = data;
    s_write = 1'b1; s_read = 1'b0;
    chk("wr_accept_wait", 64'(w_wait), 64'd0);
    step();
    s_write = 1'b0;
    s_writedata = {$urandom, $urandom};
    s_byteenable = 8'($urandom);
    if (hold_rd) s_read = 1'b1;
    else s_address = 28'($urandom);
    nb = int'(be[3:0] != 4'h0) + int'(be[7:4] != 4'h0);
    for (int k = 0; k < nb; k++) begin
      beat = !(k == 0 && be[3:0] != 4'h0);
      chk("wr_we", 64'(w_we), 64'd1);
      chk("wr_re", 64'(w_re), 64'd0);
      chk("wr_wait", 64'(w_wait), 64'd1);
      chk("wr_addr", 64'(w_addr), 64'({idx, beat}));
      chk("wr_be", 64'(w_be), 64'(beat ? be[7:4] : be[3:0]));
      chk("wr_wdata", 64'(w_wdata), 64'(beat ? data[63:32] : data[31:0]));
      step();
    end
    chk("wr_done_we", 64'(w_we), 64'd0);
    chk("wr_done_re", 64'(w_re), 64'd0);
    chk("wr_done_wait", 64'(w_wait), 64'd0);
    cur = ref_get(int'(idx));
    for (int i = 0; i < 8; i++) if (be[i]) cur[8*i +: 8] = data[8*i +: 8];
    ref_put(int'(idx), cur);
  endtask

  task automatic do_read(input logic [27:0] addr, input bit both);
    logic [20:0] idx;
    logic [63:0] exp;
    int          lat;
    int          got;
    idx = addr[23:3];
    exp = ref_get(int'(idx));
    lat = sel_b ? 3 : 1;
    got = -1;
    if (!sel_b) a_reads++;
    s_address = addr; s_read = 1'b1; s_write = both;
    s_byteenable = 8'($urandom); s_writedata = {$urandom, $urandom};
    chk("rd_accept_wait", 64'(w_wait), 64'd0);
    step();
    s_read = 1'b0; s_write = 1'b0; s_address = 28'($urandom);
    chk("rd_lo_re", 64'(w_re), 64'd1);
    chk("rd_lo_addr", 64'(w_addr), 64'({idx, 1'b0}));
    chk("rd_lo_we", 64'(w_we), 64'd0);
    chk("rd_lo_wait", 64'(w_wait), 64'd1);
    step();
    chk("rd_hi_re", 64'(w_re), 64'd1);
    chk("rd_hi_addr", 64'(w_addr), 64'({idx, 1'b1}));
    chk("rd_hi_we", 64'(w_we), 64'd0);
    for (int n = 3; n <= 12 && got < 0; n++) begin
      step();
      if (w_rv) got = n;
    end
    chk("rd_latency", 64'(got), 64'(3 + lat));
    chk("rd_data", w_rdata, exp);
    chk("rd_wait_at_valid", 64'(w_wait), 64'd0);
    step();
    chk("rd_single_pulse", 64'(w_rv), 64'd0);
    chk("rd_data_held", w_rdata, exp);
  endtask

  initial begin
    logic [27:0] ra;
    int          c0;
    reset_n = 1'b0; clr = 1'b1; sel_b = 1'b0;
    s_address = '0; s_byteenable = '0; s_read = 1'b0; s_write = 1'b0; s_writedata = '0;
    step();
    clr = 1'b0;
    step();
    chk("rst_a_wait", 64'(a_wait), 64'd0);
    chk("rst_b_wait", 64'(b_wait), 64'd0);
    chk("rst_a_rv", 64'(a_rv), 64'd0);
    chk("rst_a_strobes", 64'({a_re, a_we, b_re, b_we}), 64'd0);
    chk("rst_a_be", 64'(a_be), 64'd0);
    chk("rst_a_rdata", a_rdata, 64'd0);
    chk("rst_b_rdata", b_rdata, 64'd0);
    reset_n = 1'b1;
    step();

    // Full octa write then read back on both latencies
    do_write(28'h0000010, 8'hFF, 64'h1122334455667788, 1'b0);
    do_read(28'h0000010, 1'b0);
    sel_b = 1'b1;
    do_write(28'h0000010, 8'hFF, 64'h1122334455667788, 1'b0);
    do_read(28'h0000010, 1'b0);
    sel_b = 1'b0;

    // Single-byte write into the hi beat, other bytes preserved
    do_write(28'h0000018, 8'hFF, 64'hCAFEF00DDEADBEEF, 1'b0);
    do_write(28'h0000018, 8'h10, 64'h000000AB00000000, 1'b0);
    do_read(28'h0000018, 1'b0);
    do_write(28'h0000018, 8'h0C, 64'h0000000012340000, 1'b0);
    do_read(28'h0000018, 1'b0);

    // Empty byteenable write, and read with write asserted at the same time
    do_write(28'h0000010, 8'h00, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    do_read(28'h0000010, 1'b1);
    do_read(28'h0000010, 1'b0);

    // Aliasing: upper address bits and low three bits are ignored
    do_write(28'hF000020, 8'hFF, 64'h0123456789ABCDEF, 1'b0);
    do_read(28'h0000027, 1'b0);

    // Read held by the master across a write's waitrequest
    c0 = a_rv_cnt;
    do_write(28'h0000030, 8'hFF, 64'hA5A55A5A0F0FF0F0, 1'b1);
    do_read(28'h0000030, 1'b0);
    step();
    chk("b2b_one_pulse", 64'(a_rv_cnt - c0), 64'd1);

    // Randomized traffic against the reference model
    for (int t = 0; t < 40; t++) begin
      ra = {4'($urandom), 12'd0, 9'($urandom_range(0, 511)), 3'($urandom)};
      if ($urandom_range(0, 1) == 0)
        do_write(ra, 8'($urandom), {$urandom, $urandom}, 1'b0);
      else
        do_read(ra, 1'b0);
    end

    // Reset while waiting for read data aborts the read
    sel_b = 1'b1;
    do_write(28'h0000040, 8'hFF, 64'h7766554433221100, 1'b0);
    c0 = b_rv_cnt;
    s_address = 28'h0000040; s_read = 1'b1;
    step();
    s_read = 1'b0;
    step();
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("abort_re_drop", 64'(b_re), 64'd0);
    chk("abort_wait", 64'(b_wait), 64'd0);
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("abort_no_valid", 64'(b_rv_cnt - c0), 64'd0);
    chk("abort_idle", 64'(b_wait), 64'd0);
    do_read(28'h0000040, 1'b0);
    sel_b = 1'b0;
    do_read(28'h0000010, 1'b0);
    step();
    chk("a_pulse_count", 64'(a_rv_cnt), 64'(a_reads));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
